// File: rtl/chips_stream_pkg.sv
// Shared types and constants for the chips_stream_merge round-robin stream merger.
package chips_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    SEND   = 2'd2
  } state_t;

  localparam int DEFAULT_CHANNELS = 4;
  localparam int IDX_W            = $clog2(DEFAULT_CHANNELS + 1);
  localparam int WATCHDOG_SRC     = DEFAULT_CHANNELS;

  // Width of an exception source index, leaving room for the watchdog code.
  function automatic int idx_width(input int channels);
    return $clog2(channels + 1);
  endfunction

endpackage

// File: rtl/chips_rr_arbiter.sv
// Combinational rotating-priority arbiter: first asserted request at or above ptr, wrapping.
module chips_rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int PTR_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [PTR_W-1:0]    ptr,
  output logic [PTR_W-1:0]    grant,
  output logic                valid
);

  // Scanning from the far end down lets the request nearest to ptr win last.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    valid = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (req[PTR_W'(idx)]) begin
        grant = PTR_W'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chips_stream_merge.sv
// N-channel round-robin merger for stb/ack streams with a sticky exception aggregator.
// Optional watchdog on a stalled sink is built when CHIPS_STREAM_MERGE_WATCHDOG_EN is defined.
module chips_stream_merge
  import chips_stream_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int TIMEOUT  = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS*WIDTH-1:0]     input_in,
  input  logic [CHANNELS-1:0]           input_in_stb,
  output logic [CHANNELS-1:0]           input_in_ack,
  output logic [WIDTH-1:0]              output_out,
  output logic                          output_out_stb,
  input  logic                          output_out_ack,
  input  logic [CHANNELS-1:0]           exception_in,
  output logic                          exception,
  output logic [$clog2(CHANNELS+1)-1:0] exception_src
);

  localparam int PTR_W = $clog2(CHANNELS);
  localparam int SRC_W = idx_width(CHANNELS);

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_q;
  logic [PTR_W-1:0] arb_grant;
  logic             arb_valid;
  logic [SRC_W-1:0] low_idx;
  logic             wd_fire;

  chips_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .PTR_W    (PTR_W)
  ) u_arbiter (
    .req   (input_in_stb),
    .ptr   (ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      grant_q        <= '0;
      input_in_ack   <= '0;
      output_out     <= '0;
      output_out_stb <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant_q      <= arb_grant;
            input_in_ack <= CHANNELS'(1) << arb_grant;
            state        <= ACCEPT;
          end
        end
        ACCEPT: begin
          output_out     <= input_in[grant_q*WIDTH +: WIDTH];
          input_in_ack   <= '0;
          output_out_stb <= 1'b1;
          ptr            <= (grant_q == PTR_W'(CHANNELS - 1)) ? '0 : grant_q + 1'b1;
          state          <= SEND;
        end
        SEND: begin
          if (output_out_ack) begin
            output_out_stb <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    low_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (exception_in[i]) low_idx = SRC_W'(i);
    end
  end

`ifdef CHIPS_STREAM_MERGE_WATCHDOG_EN
  logic [15:0] wd_cnt;

  // Counter saturates at TIMEOUT so a long stall cannot wrap it back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == SEND && !output_out_ack) begin
      if (wd_cnt != 16'(TIMEOUT)) wd_cnt <= wd_cnt + 16'd1;
    end else begin
      wd_cnt <= '0;
    end
  end

  assign wd_fire = (state == SEND) && !output_out_ack && (wd_cnt == 16'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wd_fire        = 1'b0;
`endif

  // Process exception lines outrank the watchdog when both arrive together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exception     <= 1'b0;
      exception_src <= '0;
    end else if (!exception) begin
      if (|exception_in) begin
        exception     <= 1'b1;
        exception_src <= low_idx;
      end else if (wd_fire) begin
        exception     <= 1'b1;
        exception_src <= SRC_W'(CHANNELS);
      end
    end
  end

endmodule
